unidade_busca: RTL and testbench
================================

UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 imem_req  output  1  SHALL flag a valid instruction-memory read request.
REQ-005 imem_addr  output  32  SHALL carry the request word address (bits [1:0] always 0).
REQ-006 imem_ready  input  1  SHALL accept the request in any cycle where imem_req=1.
REQ-007 imem_rvalid  input  1  SHALL flag a returned instruction word.
REQ-008 imem_rdata  input  32  SHALL carry the returned instruction word.
REQ-009 redirect  input  1  SHALL flag a taken branch/jump from the datapath.
REQ-010 redirect_pc  input  32  SHALL carry the new fetch target.
REQ-011 out_valid  output  1  SHALL flag a buffered instruction available to decode.
REQ-012 out_ready  input  1  SHALL flag that decode consumes the head instruction this cycle.
REQ-013 out_instr, out_pc  output  32 each  SHALL carry the head entry's instruction and address.
REQ-014 out_opcode (7), out_funct3 (3), out_funct7 (7)  output  SHALL equal out_instr[6:0], [14:12], [31:25] combinationally.

Function
REQ-015 Internal 2-entry FIFO of {pc, instr}; out_valid = (count != 0); pop when out_valid & out_ready.
REQ-016 FSM states: REQ (no outstanding request), WAIT (one outstanding), FLUSH (one outstanding, to be discarded); at most one outstanding request at any time.
REQ-017 In REQ, imem_req=1 iff count<2; imem_addr=fetch_pc, held stable until imem_ready.
REQ-018 Handshake imem_req & imem_ready: fetch_pc <= fetch_pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0), state -> WAIT; request pc latched as tag.
REQ-019 In WAIT, imem_rvalid: push {tag, imem_rdata} into FIFO, state -> REQ; imem_req=0 in WAIT and FLUSH.
REQ-020 Push and pop in same cycle SHALL both take effect; count unchanged; FIFO cannot overflow since requests issue only when count<2.
REQ-021 redirect (highest priority): FIFO cleared (count=0, pop ignored), fetch_pc <= {redirect_pc[31:2],2'b00}; out_valid=0 next cycle.
REQ-022 Redirect state rules: REQ without handshake -> REQ; REQ with handshake same cycle -> FLUSH; WAIT without rvalid -> FLUSH; WAIT with rvalid -> REQ, response discarded; FLUSH -> FLUSH, fetch_pc updated.
REQ-023 In FLUSH, imem_rvalid SHALL be discarded (no push), state -> REQ.
REQ-024 imem_rvalid in REQ SHALL be ignored.
REQ-025 Latency: rvalid in cycle N -> out_valid=1 in cycle N+1 with that word; next request issued no earlier than cycle N+1.

Reset
REQ-026 While reset=1: imem_req=0, out_valid=0, FIFO count=0, entries zeroed (out_instr=out_pc=0), state=REQ, fetch_pc=RESET_PC.
REQ-027 Reset during WAIT/FLUSH SHALL abandon the outstanding request; its late rvalid is ignored per REQ-024.
REQ-028 First cycle after reset release: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-029 Reset release, imem_ready=1, rvalid 1 cycle after each request, out_ready=1 -> out_pc sequence 0x0,0x4,0x8 in order, opcode/funct fields match instr words.
REQ-030 out_ready=0, memory always responding -> exactly 2 entries buffered, imem_req=0 thereafter; out_ready=1 -> entries 0x0,0x4 popped in order, fetch resumes at 0x8.
REQ-031 redirect=1, redirect_pc=0x103 while in WAIT -> out_valid=0 next cycle, stale rvalid discarded, next imem_addr=0x100.
REQ-032 redirect coincident with rvalid in WAIT -> no push, state REQ, next imem_addr=redirect target; redirect coincident with pop on full FIFO -> count=0.
REQ-033 redirect_pc=0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
REQ-034 Reset asserted in WAIT, rvalid arrives 2 cycles after release -> no push, out_valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/unidade_busca.sv
// rtl/unidade_busca.sv - instruction fetch unit with one outstanding request and a 2-entry {pc, instr} buffer
module unidade_busca #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [6:0]  out_opcode,
   output logic [2:0]  out_funct3,
   output logic [6:0]  out_funct7
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_FLUSH} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_fetch_pc;
   logic [31:0] r_tag;
   logic [31:0] r_pc    [2];
   logic [31:0] r_instr [2];
   logic        r_head;
   logic [1:0]  r_count;
   logic        w_hs;
   logic        w_push;
   logic        w_pop;
   logic        w_wr_idx;
   logic        w_unused;

   assign w_unused  = ^redirect_pc[1:0];
   assign w_wr_idx  = r_head ^ r_count[0];
   assign imem_addr = r_fetch_pc;

   // Outputs are forced to their reset values combinationally so they are clean in the first reset cycle.
   assign out_valid  = (r_count != 2'd0) && !reset;
   assign out_pc     = reset ? 32'd0 : r_pc[r_head];
   assign out_instr  = reset ? 32'd0 : r_instr[r_head];
   assign out_opcode = out_instr[6:0];
   assign out_funct3 = out_instr[14:12];
   assign out_funct7 = out_instr[31:25];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_REQ;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_REQ:   if (w_hs) w_next = redirect ? S_FLUSH : S_WAIT;
         S_WAIT:  if (imem_rvalid) w_next = S_REQ;
                  else if (redirect) w_next = S_FLUSH;
         S_FLUSH: if (imem_rvalid) w_next = S_REQ;
         default: w_next = S_REQ;
      endcase
   end

   always_comb begin
      imem_req = (r_state == S_REQ) && (r_count != 2'd2) && !reset;
      w_hs     = imem_req && imem_ready;
      w_push   = (r_state == S_WAIT) && imem_rvalid && !redirect;
      w_pop    = out_valid && out_ready && !redirect;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_tag      <= 32'd0;
         r_head     <= 1'b0;
         r_count    <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_pc[i]    <= 32'd0;
            r_instr[i] <= 32'd0;
         end
      end else begin
         if (redirect) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
         end else if (w_hs) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if (w_hs) begin
            r_tag <= r_fetch_pc;
         end
         if (redirect) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
         end else begin
            if (w_push) begin
               r_pc[w_wr_idx]    <= r_tag;
               r_instr[w_wr_idx] <= imem_rdata;
            end
            if (w_pop) begin
               r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         end
      end
   end

endmodule

// File: tb/tb_unidade_busca.sv
// tb/tb_unidade_busca.sv - directed table, corner sequences and random run against a queue-based fetch model
module tb_unidade_busca;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [6:0]  out_opcode;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;

   int n_checks = 0;
   int n_errors = 0;

   unidade_busca #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, rdy, rv;
      logic [31:0] rdata;
      logic        red;
      logic [31:0] rpc;
      logic        ordy;
      logic        req;
      logic [31:0] addr;
      logic        ov;
      logic [31:0] opc, oins;
   } vec_t;

   typedef struct {
      logic [31:0] pc, instr;
   } ent_t;

   vec_t        tbl [14];
   ent_t        m_q [$];
   logic [31:0] m_fetch;
   logic        m_pend, m_flush;
   logic [31:0] m_tag;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_head(input logic [31:0] pc, input logic [31:0] ins);
      chk("out_pc", out_pc, pc);
      chk("out_instr", out_instr, ins);
      chk("opcode", {25'd0, out_opcode}, {25'd0, ins[6:0]});
      chk("funct3", {29'd0, out_funct3}, {29'd0, ins[14:12]});
      chk("funct7", {25'd0, out_funct7}, {25'd0, ins[31:25]});
   endtask

   task automatic set_in(input logic rst, input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic red, input logic [31:0] rpc, input logic ordy);
      reset = rst; imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
      redirect = red; redirect_pc = rpc; out_ready = ordy;
      #1;
   endtask

   task automatic nxt;
      @(negedge clk);
   endtask

   // Reference: one outstanding request flag plus a discard flag, and a plain queue as the buffer.
   task automatic model_step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rd,
                             input logic red, input logic [31:0] rpc, input logic ordy);
      logic hs, got;
      if (rst) begin
         m_q.delete(); m_fetch = 32'h0; m_pend = 0; m_flush = 0;
         return;
      end
      hs  = !m_pend && (m_q.size() < 2) && rdy;
      got = m_pend && rv;
      if (red) begin
         m_q.delete();
         m_fetch = {rpc[31:2], 2'b00};
         if (hs) begin m_pend = 1; m_flush = 1; end
         else if (got) begin m_pend = 0; m_flush = 0; end
         else if (m_pend) m_flush = 1;
      end else begin
         if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
         if (got && !m_flush) m_q.push_back('{m_tag, rd});
         if (got) begin m_pend = 0; m_flush = 0; end
         if (hs) begin m_tag = m_fetch; m_fetch = m_fetch + 32'd4; m_pend = 1; m_flush = 0; end
      end
   endtask

   task automatic fill_two;
      logic        rv_n;
      logic [31:0] rd_n;
      rv_n = 0; rd_n = 0;
      set_in(1, 0, 0, 0, 0, 0, 0); nxt;
      for (int i = 0; i < 6; i++) begin
         set_in(0, 1, rv_n, rd_n, 0, 0, 0);
         rv_n = imem_req;
         rd_n = mem(imem_addr);
         nxt;
      end
   endtask

   initial begin
      int          timer;
      logic [31:0] pend_addr;
      logic        r_rst, r_rdy, r_rv, r_red, r_ordy, e_req;
      logic [31:0] r_rpc;

      reset = 1; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
      redirect = 0; redirect_pc = 0; out_ready = 0;
      nxt;

      tbl[0]  = '{1, 0, 0, 32'h0,            0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0};
      tbl[1]  = '{0, 1, 0, 32'h0,            0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        32'h0};
      tbl[2]  = '{0, 0, 1, mem(32'h0),       0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0};
      tbl[3]  = '{0, 1, 0, 32'h0,            0, 32'h0,        1, 1, 32'h4,        1, 32'h0,        mem(32'h0)};
      tbl[4]  = '{0, 0, 1, mem(32'h4),       0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0};
      tbl[5]  = '{0, 1, 0, 32'h0,            0, 32'h0,        0, 1, 32'h8,        1, 32'h4,        mem(32'h4)};
      tbl[6]  = '{0, 0, 0, 32'h0,            1, 32'h103,      1, 0, 32'h0,        1, 32'h4,        mem(32'h4)};
      tbl[7]  = '{0, 0, 1, mem(32'h8),       0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0};
      tbl[8]  = '{0, 0, 0, 32'h0,            0, 32'h0,        1, 1, 32'h100,      0, 32'h0,        32'h0};
      tbl[9]  = '{0, 1, 0, 32'h0,            0, 32'h0,        1, 1, 32'h100,      0, 32'h0,        32'h0};
      tbl[10] = '{0, 0, 1, mem(32'h100),     1, 32'hFFFF_FFFC, 1, 0, 32'h0,       0, 32'h0,        32'h0};
      tbl[11] = '{0, 1, 0, 32'h0,            0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 32'h0,       32'h0};
      tbl[12] = '{0, 0, 1, mem(32'hFFFF_FFFC), 0, 32'h0,      1, 0, 32'h0,        0, 32'h0,        32'h0};
      tbl[13] = '{0, 0, 0, 32'h0,            0, 32'h0,        0, 1, 32'h0,        1, 32'hFFFF_FFFC, mem(32'hFFFF_FFFC)};

      for (int i = 0; i < 14; i++) begin
         set_in(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].red, tbl[i].rpc, tbl[i].ordy);
         chk($sformatf("tbl%0d imem_req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
         if (tbl[i].req) chk($sformatf("tbl%0d imem_addr", i), imem_addr, tbl[i].addr);
         chk($sformatf("tbl%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
         if (tbl[i].ov || tbl[i].rst) chk_head(tbl[i].opc, tbl[i].oins);
         nxt;
      end

      // Buffer fills to two entries and fetching stalls, then drains in order.
      fill_two;
      set_in(0, 0, 0, 0, 0, 0, 1);
      chk("full imem_req", {31'd0, imem_req}, 32'd0);
      chk("full out_valid", {31'd0, out_valid}, 32'd1);
      chk_head(32'h0, mem(32'h0));
      nxt;
      set_in(0, 0, 0, 0, 0, 0, 1);
      chk_head(32'h4, mem(32'h4));
      chk("resume imem_req", {31'd0, imem_req}, 32'd1);
      chk("resume imem_addr", imem_addr, 32'h8);
      nxt;
      set_in(0, 0, 0, 0, 0, 0, 0);
      chk("drained out_valid", {31'd0, out_valid}, 32'd0);
      nxt;

      // Redirect together with a pop on a full buffer empties it.
      fill_two;
      set_in(0, 0, 0, 0, 1, 32'h40, 1);
      chk("redir full out_valid", {31'd0, out_valid}, 32'd1);
      nxt;
      set_in(0, 0, 0, 0, 0, 0, 0);
      chk("redir pop out_valid", {31'd0, out_valid}, 32'd0);
      chk("redir pop imem_req", {31'd0, imem_req}, 32'd1);
      chk("redir pop imem_addr", imem_addr, 32'h40);
      nxt;

      // Reset while a request is outstanding; the late response must be ignored.
      set_in(1, 0, 0, 0, 0, 0, 0); nxt;
      set_in(0, 1, 0, 0, 0, 0, 0); nxt;
      set_in(1, 0, 0, 0, 0, 0, 0);
      chk("rst wait imem_req", {31'd0, imem_req}, 32'd0);
      nxt;
      set_in(0, 0, 0, 0, 0, 0, 0);
      chk("rel imem_req", {31'd0, imem_req}, 32'd1);
      chk("rel imem_addr", imem_addr, 32'h0);
      nxt;
      set_in(0, 0, 1, mem(32'h0), 0, 0, 0); nxt;
      set_in(0, 0, 0, 0, 0, 0, 0);
      chk("late rv out_valid", {31'd0, out_valid}, 32'd0);
      chk("late rv imem_addr", imem_addr, 32'h0);
      chk("late rv imem_req", {31'd0, imem_req}, 32'd1);
      nxt;

      timer = 0; pend_addr = 0;
      m_q.delete(); m_fetch = 0; m_pend = 0; m_flush = 0; m_tag = 0;
      for (int c = 0; c < 4000; c++) begin
         r_rst  = (c == 0) || ($urandom_range(0, 199) == 0);
         r_rdy  = ($urandom_range(0, 3) != 0);
         r_rv   = (timer == 1);
         if (timer > 0) timer--;
         r_red  = ($urandom_range(0, 15) == 0);
         r_rpc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
         r_ordy = ($urandom_range(0, 2) != 0);
         set_in(r_rst, r_rdy, r_rv, mem(pend_addr), r_red, r_rpc, r_ordy);
         if (r_rst) begin
            chk("rnd rst imem_req", {31'd0, imem_req}, 32'd0);
            chk("rnd rst out_valid", {31'd0, out_valid}, 32'd0);
            chk_head(32'h0, 32'h0);
         end else begin
            e_req = !m_pend && (m_q.size() < 2);
            chk("rnd imem_req", {31'd0, imem_req}, {31'd0, e_req});
            if (e_req) chk("rnd imem_addr", imem_addr, m_fetch);
            chk("rnd out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
            if (m_q.size() != 0) chk_head(m_q[0].pc, m_q[0].instr);
         end
         if (imem_req && r_rdy) begin
            timer = $urandom_range(1, 3);
            pend_addr = imem_addr;
         end
         model_step(r_rst, r_rdy, r_rv, mem(pend_addr), r_red, r_rpc, r_ordy);
         nxt;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
